// File: rtl/chunk_pool_refill_ctrl.sv
// Miss/refill sequencer for the 4-way chunk pool: optional dirty write-back, fetch, install.
// Optional refill/eviction statistics are compiled in with CHUNK_REFILL_STATS_EN.
module chunk_pool_refill_ctrl #(
    parameter int CHUNK_PART   = 128,
    parameter int ADDRESS_SIZE = 28,
    parameter int OFFSET_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_req,
    input  logic [ADDRESS_SIZE-1:0] data_address,
    input  logic                    data_hit,
    input  logic                    cmd_req,
    input  logic [ADDRESS_SIZE-1:0] cmd_address,
    input  logic                    cmd_hit,
    input  logic [ADDRESS_SIZE-1:0] victim_address,
    input  logic [CHUNK_PART-1:0]   victim_data,
    input  logic                    victim_dirty,
    output logic                    data_stall,
    output logic                    cmd_stall,
    output logic [ADDRESS_SIZE-1:0] new_address,
    output logic [CHUNK_PART-1:0]   new_data,
    output logic                    new_data_save,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_write,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [CHUNK_PART-1:0]   mem_write_data,
    input  logic                    mem_rvalid,
    input  logic [CHUNK_PART-1:0]   mem_rdata,
    output logic [15:0]             refill_count,
    output logic [15:0]             evict_count
);

    // state   | meaning
    // IDLE    | watch hit flags, accept one miss (data before command)
    // EVICT   | write dirty victim back, hold request until accepted
    // FETCH   | request missing chunk, hold request until accepted
    // WAIT    | wait for the single read beat
    // INSTALL | one-cycle install strobe to the pool
    // DONE    | let pool hit flags settle on the new chunk
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVICT,
        ST_FETCH,
        ST_WAIT,
        ST_INSTALL,
        ST_DONE
    } state_t;

    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK =
        {{(ADDRESS_SIZE-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDRESS_SIZE-1:0] chunk_address;
    logic                    dmiss;
    logic                    cmiss;
    logic                    evict_accept;

    assign dmiss        = data_req & ~data_hit;
    assign cmiss        = cmd_req & ~cmd_hit;
    assign evict_accept = (state == ST_EVICT) & mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (dmiss || cmiss) begin
                    state_nxt = victim_dirty ? ST_EVICT : ST_FETCH;
                end
            end
            ST_EVICT: begin
                if (mem_ready) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) state_nxt = ST_INSTALL;
            end
            ST_INSTALL: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // The source choice is folded into which address gets latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            chunk_address <= '0;
            new_address   <= '0;
            new_data      <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (dmiss) begin
                    chunk_address <= data_address & ALIGN_MASK;
                end else if (cmiss) begin
                    chunk_address <= cmd_address & ALIGN_MASK;
                end
            end
            if (state == ST_WAIT && mem_rvalid) begin
                new_data    <= mem_rdata;
                new_address <= chunk_address;
            end
        end
    end

    always_comb begin
        data_stall     = 1'b1;
        cmd_stall      = 1'b1;
        new_data_save  = 1'b0;
        mem_valid      = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            ST_IDLE: begin
                data_stall = dmiss;
                cmd_stall  = cmiss;
            end
            ST_EVICT: begin
                mem_valid      = 1'b1;
                mem_write      = 1'b1;
                mem_address    = victim_address;
                mem_write_data = victim_data;
            end
            ST_FETCH: begin
                mem_valid   = 1'b1;
                mem_address = chunk_address;
            end
            ST_INSTALL: new_data_save = 1'b1;
            default: ;
        endcase
    end

`ifdef CHUNK_REFILL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            refill_count <= '0;
            evict_count  <= '0;
        end else begin
            if (state == ST_INSTALL && refill_count != 16'hFFFF) begin
                refill_count <= refill_count + 16'd1;
            end
            if (evict_accept && evict_count != 16'hFFFF) begin
                evict_count <= evict_count + 16'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = evict_accept;
    assign refill_count = '0;
    assign evict_count  = '0;
`endif

endmodule
